// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART receiver and transmitter.
//               - rx_state_t : receiver FSM state encoding
//               - c_data_width : bits per UART character
//               - c_default_clock_freq / c_default_baud_rate : default timing
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int c_data_width         = 8;
  localparam int c_default_clock_freq = 125_000_000;
  localparam int c_default_baud_rate  = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver_if
// Description : Byte-output side of the UART receiver.
//               data_out / data_out_valid / data_out_ready : valid-ready byte
//               overrun     : one-cycle pulse, completed byte dropped
//               frame_error : one-cycle pulse, bad stop bit
//               Modport master = receiver, slave = consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_receiver_if;
  import uart_pkg::*;

  logic [c_data_width-1:0] data_out;
  logic                    data_out_valid;
  logic                    data_out_ready;
  logic                    overrun;
  logic                    frame_error;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready,
    output overrun,
    output frame_error
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready,
    input  overrun,
    input  frame_error
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous bit.
//               clk, reset (sync, active-high), i_d async in, o_q synced out.
//               RESET_VALUE sets the value both flops take in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver with a valid-ready byte output.
//   Ports     : clk, reset (sync, active-high), serial_in (async, idle high),
//               rx (uart_receiver_if.master: data_out, data_out_valid,
//               data_out_ready, overrun, frame_error).
//   Build     : define UART_RX_FRAME_ERR_EN to check the stop bit; otherwise
//               the stop sample is ignored and frame_error is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = c_default_clock_freq,
  parameter int BAUD_RATE  = c_default_baud_rate
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_in,
  uart_receiver_if.master rx
);

  localparam int c_symbol_edge_time = CLOCK_FREQ / BAUD_RATE;
  localparam int c_sample_time      = c_symbol_edge_time / 2;
  localparam int c_cnt_w            = $clog2(c_symbol_edge_time);
  localparam logic [c_cnt_w-1:0] c_sym_last = c_cnt_w'(c_symbol_edge_time - 1);
  localparam logic [c_cnt_w-1:0] c_smp_last = c_cnt_w'(c_sample_time - 1);

  logic                    w_rx;
  logic                    r_rx_prev;
  rx_state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]      r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]              r_bit_cnt, w_bit_cnt_nxt;
  logic [c_data_width-1:0] r_shift, w_shift_nxt;
  logic                    w_byte_done;
  logic [c_data_width-1:0] r_data;
  logic                    r_valid;
  logic                    r_overrun;
`ifdef UART_RX_FRAME_ERR_EN
  // Set after a low stop sample: hold in STOP until the line is high again.
  logic                    r_stop_wait, w_stop_wait_nxt;
  logic                    w_frame_bad;
  logic                    r_frame_error;
`endif

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (serial_in),
    .o_q   (w_rx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_rx_prev <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
      r_stop_wait <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_rx_prev <= w_rx;
`ifdef UART_RX_FRAME_ERR_EN
      r_stop_wait <= w_stop_wait_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt + c_cnt_w'(1);
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_byte_done   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    w_stop_wait_nxt = r_stop_wait;
    w_frame_bad     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_clk_cnt_nxt = '0;
        if (r_rx_prev && !w_rx) begin
          w_state_nxt   = START;
          w_bit_cnt_nxt = '0;
        end
      end
      START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (r_clk_cnt == c_smp_last) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = w_rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_clk_cnt == c_sym_last) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = {w_rx, r_shift[c_data_width-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
`ifdef UART_RX_FRAME_ERR_EN
        if (r_stop_wait) begin
          w_clk_cnt_nxt = '0;
          if (w_rx) begin
            w_stop_wait_nxt = 1'b0;
            w_state_nxt     = IDLE;
          end
        end else if (r_clk_cnt == c_sym_last) begin
          w_clk_cnt_nxt = '0;
          if (w_rx) begin
            w_byte_done = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_bad     = 1'b1;
            w_stop_wait_nxt = 1'b1;
          end
        end
`else
        if (r_clk_cnt == c_sym_last) begin
          w_clk_cnt_nxt = '0;
          w_byte_done   = 1'b1;
          w_state_nxt   = IDLE;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output holding register. A byte completing in the same cycle as a
  // handshake replaces the consumed byte, so valid stays high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_byte_done) begin
        if (!r_valid || rx.data_out_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx.data_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= w_frame_bad;
    end
  end
  assign rx.frame_error = r_frame_error;
`else
  assign rx.frame_error = 1'b0;
`endif

  assign rx.data_out       = r_data;
  assign rx.data_out_valid = r_valid;
  assign rx.overrun        = r_overrun;

endmodule
`default_nettype wire
